// File: rtl/bus_responder_if.sv
// CPU external bus signals between the core (master) and a memory-side
// responder (slave). The shared data bus stays a plain inout on the responder.
interface bus_responder_if;
  logic [15:0] A_BUS;
  logic        RW;
  logic        RDY;
  logic        HIT;
  logic        ERR;

  modport master (
    output A_BUS,
    output RW,
    input  RDY,
    input  HIT,
    input  ERR
  );

  modport slave (
    input  A_BUS,
    input  RW,
    output RDY,
    output HIT,
    output ERR
  );
endinterface

// File: rtl/bus_responder.sv
// Memory-side bus responder: RAM window plus fixed vector block at $FFFA-$FFFF,
// with programmable wait states signalled through RDY.
module bus_responder #(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] NMI_VEC     = 16'h0300,
  parameter logic [15:0] RST_VEC     = 16'h0200,
  parameter logic [15:0] IRQ_VEC     = 16'h0400
) (
  input  logic              clk,
  input  logic              RST,
  bus_responder_if.slave    bus,
  inout  wire  [7:0]        D_BUS
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [3:0] CNT_INIT =
    4'((WAIT_STATES > 1) ? (WAIT_STATES - 2) : 0);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic        rw_q;
  logic [7:0]  rdata_q;
  logic        err_q;

  logic [7:0]  mem_q [0:(1 << ADDR_BITS) - 1];

  logic        hit;
  logic [15:0] rd_addr;
  logic [7:0]  vec_byte;
  logic [7:0]  rd_data;

  function automatic logic is_vec(input logic [15:0] a);
    return a >= 16'hFFFA;
  endfunction

  function automatic logic is_ram(input logic [15:0] a);
    return (a[15:ADDR_BITS] == ADDR_BASE[15:ADDR_BITS]) && !is_vec(a);
  endfunction

  assign hit = is_vec(bus.A_BUS) || is_ram(bus.A_BUS);

  // With one wait state the read is captured straight from the live address.
  assign rd_addr = (state_q == S_IDLE) ? bus.A_BUS : addr_q;

  always_comb begin
    vec_byte = 8'h00;
    unique case (rd_addr[2:0])
      3'b010:  vec_byte = NMI_VEC[7:0];
      3'b011:  vec_byte = NMI_VEC[15:8];
      3'b100:  vec_byte = RST_VEC[7:0];
      3'b101:  vec_byte = RST_VEC[15:8];
      3'b110:  vec_byte = IRQ_VEC[7:0];
      3'b111:  vec_byte = IRQ_VEC[15:8];
      default: vec_byte = 8'h00;
    endcase
  end

  assign rd_data = is_vec(rd_addr) ? vec_byte
                 : mem_q[rd_addr[ADDR_BITS-1:0]];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      rw_q    <= 1'b1;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            addr_q <= bus.A_BUS;
            rw_q   <= bus.RW;
            if (WAIT_STATES == 1) begin
              rdata_q <= rd_data;
              state_q <= S_ACK;
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.A_BUS != addr_q || bus.RW != rw_q) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd0) begin
            rdata_q <= rd_data;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Not reset: an async reset forces IDLE, so an ACK-cycle write is dropped.
  always_ff @(posedge clk) begin
    if (state_q == S_ACK && !rw_q && is_ram(addr_q)) begin
      mem_q[addr_q[ADDR_BITS-1:0]] <= D_BUS;
    end
  end

  assign bus.HIT = hit;
  assign bus.ERR = err_q;
  assign bus.RDY = (state_q == S_IDLE) ? !hit : (state_q == S_ACK);
  assign D_BUS   = (state_q == S_ACK && rw_q) ? rdata_q : 8'bz;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: handshake timing, RAM and vector data,
// misses, protocol aborts and asynchronous reset; D_BUS is pulled up.
module tb_bus_responder;
  localparam int WS = 2;

  logic       clk = 1'b0;
  logic       RST;
  logic       tb_oe;
  logic [7:0] tb_dout;
  wire  [7:0] d_bus;

  int vectors     = 0;
  int miscompares = 0;

  bus_responder_if bus ();

  pullup (d_bus);
  assign d_bus = tb_oe ? tb_dout : 8'bz;

  bus_responder #(
    .ADDR_BASE   (16'h0000),
    .ADDR_BITS   (12),
    .WAIT_STATES (WS),
    .NMI_VEC     (16'h0300),
    .RST_VEC     (16'h0200),
    .IRQ_VEC     (16'h0400)
  ) dut (
    .clk   (clk),
    .RST   (RST),
    .bus   (bus),
    .D_BUS (d_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts just after a posedge with the FSM idle; ends just after the
  // posedge that closes ACK, with the bus parked on a miss address.
  task automatic do_access(input logic [15:0] a,
                           input logic        rw,
                           input logic [7:0]  wd,
                           input logic [7:0]  exp,
                           input bit          chk,
                           input string       tag);
    bus.A_BUS = a;
    bus.RW    = rw;
    tb_dout   = wd;
    tb_oe     = !rw;
    for (int i = 0; i < WS; i++) begin
      @(negedge clk);
      check({tag, "_rdy_lo"}, 16'(bus.RDY), 16'h0);
    end
    @(negedge clk);
    check({tag, "_rdy_ack"}, 16'(bus.RDY), 16'h1);
    if (rw && chk) check({tag, "_data"}, 16'(d_bus), 16'(exp));
    @(posedge clk);
    #1;
    tb_oe     = 1'b0;
    bus.A_BUS = 16'h8000;
    bus.RW    = 1'b1;
  endtask

  initial begin
    RST       = 1'b0;
    tb_oe     = 1'b0;
    tb_dout   = 8'h00;
    bus.A_BUS = 16'h8000;
    bus.RW    = 1'b1;
    #3;
    check("rst_rdy", 16'(bus.RDY), 16'h1);
    check("rst_hit", 16'(bus.HIT), 16'h0);
    check("rst_err", 16'(bus.ERR), 16'h0);
    check("rst_dbus_z", 16'(d_bus), 16'h00FF);

    repeat (2) @(posedge clk);
    #1;
    RST = 1'b1;
    do_access(16'h0010, 1'b1, 8'h00, 8'h00, 1'b0, "first_rd");

    do_access(16'h0123, 1'b0, 8'hA5, 8'h00, 1'b0, "wr_0123");
    do_access(16'h0123, 1'b1, 8'h00, 8'hA5, 1'b1, "rd_0123");

    do_access(16'hFFFC, 1'b1, 8'h00, 8'h00, 1'b1, "vec_fffc");
    do_access(16'hFFFD, 1'b1, 8'h00, 8'h02, 1'b1, "vec_fffd");
    do_access(16'hFFFC, 1'b0, 8'h55, 8'h00, 1'b0, "vec_wr");
    do_access(16'hFFFC, 1'b1, 8'h00, 8'h00, 1'b1, "vec_fffc2");
    do_access(16'hFFFB, 1'b1, 8'h00, 8'h03, 1'b1, "vec_fffb");
    do_access(16'hFFFF, 1'b1, 8'h00, 8'h04, 1'b1, "vec_ffff");

    bus.A_BUS = 16'h9000;
    bus.RW    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("miss_rdy", 16'(bus.RDY), 16'h1);
      check("miss_hit", 16'(bus.HIT), 16'h0);
      check("miss_dbus_z", 16'(d_bus), 16'h00FF);
    end
    @(posedge clk);
    #1;
    do_access(16'h0123, 1'b1, 8'h00, 8'hA5, 1'b1, "after_miss");

    bus.A_BUS = 16'h0040;
    bus.RW    = 1'b1;
    @(negedge clk);
    check("viol_rdy0", 16'(bus.RDY), 16'h0);
    @(posedge clk);
    #1;
    bus.A_BUS = 16'h0041;
    @(negedge clk);
    check("viol_err_pre", 16'(bus.ERR), 16'h0);
    @(posedge clk);
    #1;
    check("viol_err", 16'(bus.ERR), 16'h1);
    do_access(16'h0041, 1'b0, 8'h96, 8'h00, 1'b0, "post_viol_wr");
    check("viol_err_sticky", 16'(bus.ERR), 16'h1);
    do_access(16'h0041, 1'b1, 8'h00, 8'h96, 1'b1, "post_viol_rd");

    bus.A_BUS = 16'h0123;
    bus.RW    = 1'b1;
    repeat (3) @(negedge clk);
    check("ack_dbus", 16'(d_bus), 16'h00A5);
    #1;
    RST = 1'b0;
    #1;
    check("rst_ack_dbus_z", 16'(d_bus), 16'h00FF);
    check("rst_ack_err", 16'(bus.ERR), 16'h0);
    check("rst_ack_rdy", 16'(bus.RDY), 16'h0);
    bus.A_BUS = 16'h8000;
    @(posedge clk);
    #1;
    RST = 1'b1;

    do_access(16'h0200, 1'b0, 8'h77, 8'h00, 1'b0, "wr_0200");
    bus.A_BUS = 16'h0200;
    bus.RW    = 1'b0;
    tb_dout   = 8'h3C;
    tb_oe     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    #1;
    tb_oe     = 1'b0;
    bus.A_BUS = 16'h8000;
    bus.RW    = 1'b1;
    #1;
    check("rst_wait_dbus_z", 16'(d_bus), 16'h00FF);
    @(posedge clk);
    #1;
    RST = 1'b1;
    do_access(16'h0200, 1'b1, 8'h00, 8'h77, 1'b1, "rd_0200");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the CPU's external bus. It decodes `A_BUS`/`RW` and serves a single-port RAM window plus a fixed vector block at `$FFFA-$FFFF`. It inserts a programmable number of wait states by driving the CPU's `RDY` input low, and it drives `D_BUS` during read completion. It sits between the CPU core and the system memory map, acting as the target end of the CPU bus protocol.

## Interface
- `ADDR_BASE`, default 16'h0000: RAM window base. Only bits [15:ADDR_BITS] are compared.
- `ADDR_BITS`, default 12: RAM size is 2^ADDR_BITS bytes. Legal range 8..14.
- `WAIT_STATES`, default 2: number of cycles `RDY` is held low per hit access. Legal range 1..15; 0 is illegal.
- `NMI_VEC`, default 16'h0300: returned at `$FFFA` (low byte) / `$FFFB` (high byte).
- `RST_VEC`, default 16'h0200: returned at `$FFFC` / `$FFFD`.
- `IRQ_VEC`, default 16'h0400: returned at `$FFFE` / `$FFFF`.
- `clk`, input, 1: single clock. All state updates on posedge.
- `RST`, input, 1: asynchronous, active-low reset.
- `A_BUS`, input, 16: CPU address.
- `RW`, input, 1: 1 = read, 0 = write.
- `D_BUS`, inout, 8: shared data bus. Driven only as specified below, otherwise high-Z.
- `RDY`, output, 1: CPU ready. 0 stalls the CPU, which holds `A_BUS`, `RW` and write data stable.
- `HIT`, output, 1: combinational decode of the current `A_BUS`, i.e. RAM window or vector block.
- `ERR`, output, 1: sticky protocol-violation flag. Cleared only by reset.

## Operation
- Decode:
  - `vec_hit` = `A_BUS` >= 16'hFFFA.
  - `ram_hit` = (`A_BUS`[15:ADDR_BITS] == `ADDR_BASE`[15:ADDR_BITS]) && !vec_hit.
  - `HIT` = vec_hit || ram_hit. Vector block has priority over the RAM window.
- State machine: IDLE, WAIT, ACK.
  - **IDLE**
    - `RDY` = !HIT (combinational).
    - On posedge with HIT, latch `addr_q`←`A_BUS` and `rw_q`←`RW`.
    - If WAIT_STATES==1: capture read data into `rdata_q`, then go to ACK.
    - Otherwise: load `cnt`←WAIT_STATES-2, then go to WAIT.
    - No HIT: stay in IDLE.
  - **WAIT**
    - `RDY`=0.
    - If `A_BUS`!=`addr_q` or `RW`!=`rw_q` at a posedge: set `ERR`, go to IDLE, no memory write.
    - Else if `cnt`==0: capture `rdata_q`, go to ACK.
    - Else decrement `cnt`.
  - **ACK**
    - `RDY`=1.
    - If `rw_q`=1, drive `D_BUS`=`rdata_q`.
    - On posedge, if `rw_q`=0 and the access is a RAM hit, write `mem[addr_q[ADDR_BITS-1:0]]`←`D_BUS`.
    - Always go to IDLE.
- Read data capture:
  - RAM hit: `mem[addr]`.
  - Vector hit: the selected vector byte. Even address = low byte, odd address = high byte.
- Writes to the vector block complete the handshake normally but are discarded.
- Back-to-back accesses, including repeated accesses to the same address (RMW), are separate transactions. ACK always returns to IDLE, which re-decodes.
- Miss addresses: `RDY`=1, `D_BUS` high-Z, no state change.
- RAM contents are not initialised or cleared by reset.

## Timing
- Reset (`RST`=0, asynchronous):
  - State is IDLE; `cnt`=0, `ERR`=0.
  - `D_BUS` is released immediately, not waiting for a clock edge.
  - `RDY` follows the IDLE decode (1 for a miss address).
  - A write in progress is abandoned and memory is untouched.
- Each hit access holds `RDY` low for exactly WAIT_STATES cycles, then one ACK cycle.
- Throughput is WAIT_STATES+1 cycles per hit access. Misses cost no extra cycles.
- Read data is valid on `D_BUS` for the whole ACK cycle. `D_BUS` is high-Z in IDLE and WAIT, and in ACK for writes.
- Write data is sampled at the posedge that ends ACK.
- `RDY` is combinational from `A_BUS` in IDLE only. In WAIT and ACK it depends on state alone.
- An `ERR` abort returns to IDLE at that edge. The new address is decoded in the following cycle as a fresh access.

## Test plan
- **Reset:**
  - Stimulus: assert `RST`=0 with `A_BUS`=16'h8000.
  - Required: `RDY`=1, `HIT`=0, `ERR`=0, `D_BUS`=Z.
  - Stimulus: release reset, then present 16'h0010 read.
  - Required: `RDY`=0 in the same cycle.
- **Write then read, WAIT_STATES=2:**
  - Stimulus: write 8'hA5 to 16'h0123, then read 16'h0123.
  - Required: each access shows `RDY` low for 2 cycles, then 1 ACK cycle. The read returns 8'hA5 on `D_BUS` during ACK.
- **Vectors:**
  - Stimulus: read 16'hFFFC, then 16'hFFFD.
  - Required: returns 8'h00, then 8'h02.
  - Stimulus: write 8'h55 to 16'hFFFC, then read it again.
  - Required: still returns 8'h00.
- **Miss:**
  - Stimulus: read 16'h9000 with ADDR_BASE=0, ADDR_BITS=12.
  - Required: `RDY` stays 1, `D_BUS` Z, `HIT`=0, FSM stays in IDLE.
- **Protocol violation:**
  - Stimulus: start a read at 16'h0040, change `A_BUS` to 16'h0041 during WAIT.
  - Required: `ERR`=1 at the next edge and stays 1. FSM returns to IDLE. A following write to 16'h0041 completes normally.
- **Reset mid-access:**
  - Stimulus: start a write of 8'h3C to 16'h0200, assert `RST`=0 during WAIT, then release and read 16'h0200.
  - Required: `D_BUS` is Z immediately on reset, and the read does not return 8'h3C (prior contents preserved).
